// File: rtl/lfsr_seg_pkg.sv
// Shared constants for the LFSR segment engine: mode codes, default polynomial/seed
// and the hex-to-7-segment glyph table.
package lfsr_seg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_RUN  = 2'b01;
  localparam logic [1:0] MODE_STEP = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  localparam logic [15:0] DEFAULT_TAPS = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Active-high gfedcba glyphs for 0-9, A, b, C, d, E, F
  function automatic logic [6:0] hex_to_seg7(input logic [3:0] nibble);
    logic [6:0] seg;
    case (nibble)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      default: seg = 7'b1110001;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/lfsr_seg_engine_step_sync.sv
// Brings the asynchronous step pin into the clock domain and turns each rising
// edge into a single registered one-cycle pulse.
module lfsr_step_sync (
  input  logic clk,
  input  logic rst,
  input  logic ena,
  input  logic step_pin,
  output logic pulse
);

  logic sync_a;
  logic sync_b;
  logic level_q;

  // The synchroniser keeps sampling even while disabled so the pin level is never stale
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= 1'b0;
      sync_b <= 1'b0;
    end else begin
      sync_a <= step_pin;
      sync_b <= sync_a;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_q <= 1'b0;
      pulse   <= 1'b0;
    end else if (ena) begin
      level_q <= sync_b;
      pulse   <= sync_b & ~level_q;
    end
  end

endmodule

// File: rtl/lfsr_seg_engine.sv
// Galois LFSR pattern engine with HOLD/RUN/STEP/LOAD modes, a power-of-two
// prescaler, wrap detection against the last loaded value and a hex glyph output.
module lfsr_seg_engine
  import lfsr_seg_pkg::*;
#(
  parameter int                WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = DEFAULT_TAPS[WIDTH-1:0],
  parameter logic [WIDTH-1:0]  SEED  = DEFAULT_SEED[WIDTH-1:0],
  parameter int                DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             step,
  input  logic [3:0]       div_sel,
  input  logic [WIDTH-1:0] seed_in,
  output logic [WIDTH-1:0] state,
  output logic [6:0]       segments,
  output logic             adv,
  output logic             wrap,
  output logic             zero_sub
);

  localparam logic [DIV_W-1:0] ALL_ONES = '1;

  logic [WIDTH-1:0] origin;
  logic [WIDTH-1:0] next_state;
  logic [WIDTH-1:0] load_value;
  logic [DIV_W-1:0] presc;
  logic [DIV_W-1:0] presc_top;
  logic [1:0]       mode_q;
  logic [3:0]       div_q;
  logic             step_pulse;
  logic             cfg_change;
  logic             presc_done;
  logic             do_adv;
  logic             load_zero;

  lfsr_step_sync u_step_sync (
    .clk      (clk),
    .rst      (rst),
    .ena      (ena),
    .step_pin (step),
    .pulse    (step_pulse)
  );

  // Any mode or rate change costs one settling cycle with no advance
  always_comb begin
    next_state = (state >> 1) ^ (state[0] ? TAPS : '0);
    presc_top  = ~(ALL_ONES << div_sel);
    if (int'(div_sel) > DIV_W - 1)
      presc_top = ALL_ONES >> 1;
    cfg_change = (mode != mode_q) || (div_sel != div_q);
    presc_done = (presc == presc_top);
    do_adv     = !cfg_change &&
                 (((mode == MODE_RUN) && presc_done) ||
                  ((mode == MODE_STEP) && step_pulse));
    load_zero  = (seed_in == '0);
    load_value = load_zero ? SEED : seed_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= SEED;
      origin   <= SEED;
      presc    <= '0;
      mode_q   <= MODE_HOLD;
      div_q    <= '0;
      segments <= hex_to_seg7(SEED[3:0]);
      adv      <= 1'b0;
      wrap     <= 1'b0;
      zero_sub <= 1'b0;
    end else if (!ena) begin
      adv      <= 1'b0;
      wrap     <= 1'b0;
      zero_sub <= 1'b0;
    end else begin
      mode_q   <= mode;
      div_q    <= div_sel;
      segments <= hex_to_seg7(state[3:0]);
      adv      <= 1'b0;
      wrap     <= 1'b0;
      zero_sub <= 1'b0;

      if ((mode == MODE_RUN) && !cfg_change && !presc_done)
        presc <= presc + 1'b1;
      else
        presc <= '0;

      // A zero state can only arise from an upset; recover before anything else
      if (mode == MODE_LOAD) begin
        state    <= load_value;
        origin   <= load_value;
        zero_sub <= load_zero;
      end else if (state == '0) begin
        state    <= SEED;
        zero_sub <= 1'b1;
      end else if (do_adv) begin
        state <= next_state;
        adv   <= 1'b1;
        wrap  <= (next_state == origin);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_seg_engine.sv
// Randomised bench for lfsr_seg_engine: a default 16-bit instance plus a 4-bit
// instance used for full-period wrap checks, both compared against a behavioural model.
module tb_lfsr_seg_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [1:0]  mode;
  logic        step;
  logic [3:0]  div_sel;
  logic [15:0] seed_in;

  logic [15:0] state;
  logic [6:0]  segments;
  logic        adv, wrap, zero_sub;

  logic [3:0]  state_s;
  logic [6:0]  segments_s;
  logic        adv_s, wrap_s, zero_sub_s;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [6:0] glyph_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 clk = ~clk;

  lfsr_seg_engine dut (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .step(step),
    .div_sel(div_sel), .seed_in(seed_in), .state(state), .segments(segments),
    .adv(adv), .wrap(wrap), .zero_sub(zero_sub)
  );

  lfsr_seg_engine #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .DIV_W(16)) dut_s (
    .clk(clk), .rst(rst), .ena(ena), .mode(mode), .step(step),
    .div_sel(div_sel), .seed_in(seed_in[3:0]), .state(state_s), .segments(segments_s),
    .adv(adv_s), .wrap(wrap_s), .zero_sub(zero_sub_s)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [3:0] d,
                               input logic [15:0] s, input logic e);
    mode    = m;
    div_sel = d;
    seed_in = s;
    ena     = e;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference advance: shift right, fold the tap mask in when a one falls out
  function automatic logic [15:0] lfsr_next(input logic [15:0] s, input int w, input logic [15:0] taps);
    logic [15:0] mask;
    mask = 16'((32'd1 << w) - 1);
    return ((s >> 1) ^ (s[0] ? taps : 16'h0)) & mask;
  endfunction

  function automatic logic [15:0] adv16(input logic [15:0] s, input int k);
    logic [15:0] r;
    r = s;
    for (int i = 0; i < k; i++) r = lfsr_next(r, 16, 16'hB400);
    return r;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] s, exp_s;
    logic [3:0]  sm;
    logic        seen [16];
    int d, n, n2, adv_cnt, wrap_cnt, pulses;

    rst  = 1'b1;
    step = 1'b0;
    applyStimulus(2'b00, 4'd0, 16'h0, 1'b1);
    tick();
    tick();
    checkOutput("reset_state", state, 16'hACE1);
    checkOutput("reset_segments", segments, 7'b0000110);
    checkOutput("reset_adv", adv, 0);
    checkOutput("reset_wrap", wrap, 0);
    checkOutput("reset_zero_sub", zero_sub, 0);
    checkOutput("reset_small_state", state_s, 4'h1);
    rst = 1'b0;

    // RUN at full rate: settling cycle, then one advance per cycle
    applyStimulus(2'b01, 4'd0, 16'h0, 1'b1);
    tick();
    checkOutput("run_settle_state", state, 16'hACE1);
    checkOutput("run_settle_adv", adv, 0);
    tick();
    checkOutput("run0_state1", state, 16'hE270);
    checkOutput("run0_adv1", adv, 1);
    checkOutput("run0_seg1", segments, glyph_tab[4'h1]);
    tick();
    checkOutput("run0_state2", state, 16'h7138);
    checkOutput("run0_adv2", adv, 1);
    checkOutput("run0_seg2", segments, glyph_tab[4'h0]);
    tick();
    checkOutput("run0_state3", state, 16'h389C);
    checkOutput("run0_seg3", segments, glyph_tab[4'h8]);

    applyStimulus(2'b01, 4'd2, 16'h0, 1'b1);
    adv_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      tick();
      if (adv) adv_cnt++;
    end
    checkOutput("run2_adv_count", adv_cnt, 3);
    checkOutput("run2_state", state, adv16(16'h389C, 3));

    // Random seeds and rates: advances = floor((cycles-1) / 2^div)
    for (int t = 0; t < 6; t++) begin
      s = 16'($urandom_range(1, 16'hFFFF));
      d = $urandom_range(0, 4);
      n = $urandom_range(1, 40);
      applyStimulus(2'b11, 4'd0, s, 1'b1);
      tick();
      checkOutput("load_rand_state", state, s);
      checkOutput("load_rand_zero_sub", zero_sub, 0);
      applyStimulus(2'b01, 4'(d), s, 1'b1);
      adv_cnt = 0;
      wrap_cnt = 0;
      for (int i = 0; i < n; i++) begin
        tick();
        if (adv) adv_cnt++;
        if (wrap) wrap_cnt++;
      end
      checkOutput("run_rand_state", state, adv16(s, (n - 1) >> d));
      checkOutput("run_rand_adv_count", adv_cnt, (n - 1) >> d);
      checkOutput("run_rand_wrap_count", wrap_cnt, 0);
    end

    // Enable freeze in the middle of a divided run
    s  = 16'($urandom_range(1, 16'hFFFF));
    n  = $urandom_range(2, 12);
    n2 = $urandom_range(1, 12);
    applyStimulus(2'b11, 4'd0, s, 1'b1);
    tick();
    applyStimulus(2'b01, 4'd2, s, 1'b1);
    for (int i = 0; i < n; i++) tick();
    exp_s = adv16(s, (n - 1) >> 2);
    applyStimulus(2'b01, 4'd2, s, 1'b0);
    adv_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (adv) adv_cnt++;
    end
    checkOutput("freeze_state", state, exp_s);
    checkOutput("freeze_adv_count", adv_cnt, 0);
    applyStimulus(2'b01, 4'd2, s, 1'b1);
    for (int i = 0; i < n2; i++) tick();
    checkOutput("resume_state", state, adv16(s, (n + n2 - 1) >> 2));

    // STEP: latency of three edges, held level counts once
    applyStimulus(2'b11, 4'd0, 16'hACE1, 1'b1);
    tick();
    applyStimulus(2'b10, 4'd0, 16'hACE1, 1'b1);
    tick();
    tick();
    step = 1'b1;
    tick();
    tick();
    tick();
    checkOutput("step_latency_before", state, 16'hACE1);
    tick();
    checkOutput("step_first_state", state, 16'hE270);
    checkOutput("step_first_adv", adv, 1);
    adv_cnt = 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (adv) adv_cnt++;
    end
    checkOutput("step_held_adv_count", adv_cnt, 0);
    checkOutput("step_held_state", state, 16'hE270);
    step = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    step = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    checkOutput("step_second_state", state, 16'h7138);

    step = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    pulses = $urandom_range(2, 6);
    adv_cnt = 0;
    for (int p = 0; p < pulses; p++) begin
      n = $urandom_range(1, 4);
      step = 1'b1;
      for (int i = 0; i < n; i++) begin tick(); if (adv) adv_cnt++; end
      n = $urandom_range(2, 5);
      step = 1'b0;
      for (int i = 0; i < n; i++) begin tick(); if (adv) adv_cnt++; end
    end
    for (int i = 0; i < 5; i++) begin tick(); if (adv) adv_cnt++; end
    checkOutput("step_rand_adv_count", adv_cnt, pulses);
    checkOutput("step_rand_state", state, adv16(16'h7138, pulses));

    // LOAD: zero seed is substituted, nonzero seed taken as-is
    applyStimulus(2'b11, 4'd0, 16'h0000, 1'b1);
    tick();
    checkOutput("load_zero_state", state, 16'hACE1);
    checkOutput("load_zero_sub", zero_sub, 1);
    applyStimulus(2'b00, 4'd0, 16'h0000, 1'b1);
    tick();
    checkOutput("load_zero_sub_clear", zero_sub, 0);
    applyStimulus(2'b11, 4'd0, 16'h0001, 1'b1);
    tick();
    checkOutput("load_one_state", state, 16'h0001);
    checkOutput("load_one_zero_sub", zero_sub, 0);
    applyStimulus(2'b01, 4'd0, 16'h0001, 1'b1);
    tick();
    tick();
    checkOutput("load_one_run_state", state, 16'hB400);
    checkOutput("load_one_run_wrap", wrap, 0);

    // Asynchronous reset between clock edges
    tick();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_reset_state", state, 16'hACE1);
    checkOutput("async_reset_segments", segments, 7'b0000110);
    checkOutput("async_reset_adv", adv, 0);
    tick();
    rst = 1'b0;

    // Full period of the 4-bit instance: 15 distinct states, wrap on the 15th advance only
    applyStimulus(2'b01, 4'd0, 16'h0, 1'b1);
    tick();
    checkOutput("small_settle_state", state_s, 4'h1);
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    seen[1] = 1'b1;
    sm = 4'h1;
    wrap_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      sm = 4'(lfsr_next(16'(sm), 4, 16'h000C));
      checkOutput("small_state", state_s, sm);
      checkOutput("small_wrap", wrap_s, (k == 15) ? 1 : 0);
      if (k < 15) begin
        checkOutput("small_no_repeat", seen[state_s], 0);
        seen[state_s] = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
